// File: rtl/alu16_seq.sv
// 16-bit arithmetic sequencer that drives an external 8-bit ALU in two byte passes (ADD16, ADDSP, INC16, DEC16).
// Latency: 3 cycles from the edge that samples start to done; issue interval is at least 4 cycles.
// No backpressure: start is only sampled in IDLE and is dropped otherwise; busy flags the non-accepting states.

package alu16_seq_pkg;
  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_ADC = 2'd1,
    ALU_SUB = 2'd2,
    ALU_SBC = 2'd3
  } alu_op_t;

  localparam logic [1:0] OP_ADD16 = 2'd0;
  localparam logic [1:0] OP_ADDSP = 2'd1;
  localparam logic [1:0] OP_INC16 = 2'd2;
  localparam logic [1:0] OP_DEC16 = 2'd3;
endpackage

module alu16_seq
  import alu16_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op16,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
  input  flags_t      flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output flags_t      flags_out,
  output logic        alu_en,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output alu_op_t     alu_op,
  output flags_t      alu_flags,
  input  logic [7:0]  alu_res,
  input  flags_t      alu_flags_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  flags_t      r_flags;
  logic [7:0]  r_lo;
  logic        r_lo_h;
  logic        r_lo_c;
  logic [15:0] r_result;
  flags_t      r_flags_out;
  flags_t      w_final_flags;
  logic        w_unused_alu_zn;

  // Z and N from the ALU never reach the 16-bit flags
  assign w_unused_alu_zn = &{1'b0, alu_flags_out.z, alu_flags_out.n};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: only the IDLE exit waits on start, the rest walk forward
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOW;
      S_LOW:   w_next = S_HIGH;
      S_HIGH:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the request; operands are frozen for the whole operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= 2'd0;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_flags <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_op    <= op16;
      r_a     <= a16;
      r_b     <= b16;
      r_flags <= flags_in;
    end
  end

  // Keep the low-byte result and its carries for the high pass and ADDSP flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo   <= 8'h00;
      r_lo_h <= 1'b0;
      r_lo_c <= 1'b0;
    end else if (r_state == S_LOW) begin
      r_lo   <= alu_res;
      r_lo_h <= alu_flags_out.h;
      r_lo_c <= alu_flags_out.c;
    end
  end

  // Flags reported for the completed 16-bit operation
  always_comb begin
    w_final_flags = r_flags;
    case (r_op)
      OP_ADD16: w_final_flags = '{z: r_flags.z, n: 1'b0, h: alu_flags_out.h, c: alu_flags_out.c};
      OP_ADDSP: w_final_flags = '{z: 1'b0, n: 1'b0, h: r_lo_h, c: r_lo_c};
      default:  w_final_flags = r_flags;
    endcase
  end

  // Publish result and flags at the end of the high pass; held until the next completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= 16'h0000;
      r_flags_out <= '0;
    end else if (r_state == S_HIGH) begin
      r_result    <= {alu_res, r_lo};
      r_flags_out <= w_final_flags;
    end
  end

  // ALU operand steering; everything parked at zero/ADD when the ALU is not in use
  always_comb begin
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = ALU_ADD;
    alu_flags = '0;
    case (r_state)
      S_LOW: begin
        alu_a       = r_a[7:0];
        alu_flags   = r_flags;
        alu_flags.c = 1'b0;
        case (r_op)
          OP_INC16: begin alu_b = 8'h01; alu_op = ALU_ADD; end
          OP_DEC16: begin alu_b = 8'h01; alu_op = ALU_SUB; end
          default:  begin alu_b = r_b[7:0]; alu_op = ALU_ADD; end
        endcase
      end
      S_HIGH: begin
        alu_a       = r_a[15:8];
        alu_flags   = r_flags;
        alu_flags.c = r_lo_c;
        case (r_op)
          OP_ADD16: begin alu_b = r_b[15:8]; alu_op = ALU_ADC; end
          OP_ADDSP: begin alu_b = {8{r_b[7]}}; alu_op = ALU_ADC; end
          OP_INC16: begin alu_b = 8'h00; alu_op = ALU_ADC; end
          default:  begin alu_b = 8'h00; alu_op = ALU_SBC; end
        endcase
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign alu_en    = (r_state == S_LOW) || (r_state == S_HIGH);
  assign result    = r_result;
  assign flags_out = r_flags_out;

endmodule

// File: tb/tb_alu16_seq.sv
module tb_alu16_seq;
  import alu16_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op16;
  logic [15:0] a16;
  logic [15:0] b16;
  flags_t      flags_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  flags_t      flags_out;
  logic        alu_en;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  alu_op_t     alu_op;
  flags_t      alu_flags;
  logic [7:0]  alu_res;
  flags_t      alu_flags_out;

  int checks = 0;
  int errors = 0;

  alu16_seq dut (
    .clk(clk), .rst(rst), .start(start), .op16(op16), .a16(a16), .b16(b16),
    .flags_in(flags_in), .busy(busy), .done(done), .result(result),
    .flags_out(flags_out), .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_flags(alu_flags), .alu_res(alu_res),
    .alu_flags_out(alu_flags_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Byte ALU the sequencer talks to
  logic [8:0] t9;
  logic [4:0] t5;
  logic       cin;
  always_comb begin
    cin = 1'b0;
    t9 = '0;
    t5 = '0;
    alu_flags_out = '0;
    case (alu_op)
      ALU_ADD, ALU_ADC: begin
        cin = (alu_op == ALU_ADC) && alu_flags.c;
        t9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, cin};
        t5 = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, cin};
        alu_flags_out.n = 1'b0;
      end
      default: begin
        cin = (alu_op == ALU_SBC) && alu_flags.c;
        t9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, cin};
        t5 = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'd0, cin};
        alu_flags_out.n = 1'b1;
      end
    endcase
    alu_res = t9[7:0];
    alu_flags_out.z = (t9[7:0] == 8'h00);
    alu_flags_out.h = t5[4];
    alu_flags_out.c = t9[8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the 16-bit operation must produce, from plain arithmetic
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] f, output logic [15:0] r, output logic [3:0] fl);
    int ia, ib, sb;
    ia = int'(a);
    ib = int'(b);
    sb = int'($signed(b[7:0]));
    case (op)
      2'd0: begin
        r  = 16'(ia + ib);
        fl = {f[3], 1'b0, ((ia % 4096) + (ib % 4096)) > 4095, (ia + ib) > 65535};
      end
      2'd1: begin
        r  = 16'(ia + sb);
        fl = {1'b0, 1'b0, ((ia % 16) + (ib % 16)) > 15, ((ia % 256) + (ib % 256)) > 255};
      end
      2'd2: begin r = 16'(ia + 1); fl = f; end
      default: begin r = 16'(ia - 1); fl = f; end
    endcase
  endfunction

  // Model of the transaction: ph counts cycles since acceptance (0 = idle)
  int          ph = 0;
  logic [1:0]  m_op = '0;
  logic [15:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]  m_f = '0, m_flg = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_res = '0; m_flg = '0;
    end else begin
      case (ph)
        0: if (start) begin m_op = op16; m_a = a16; m_b = b16; m_f = flags_in; ph = 1; end
        1: ph = 2;
        2: begin model(m_op, m_a, m_b, m_f, m_res, m_flg); ph = 3; end
        default: ph = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  logic [7:0] e_a, e_b;
  alu_op_t    e_op;
  logic       e_c;
  always @(negedge clk) begin
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 3);
    chk("alu_en", alu_en, (ph == 1) || (ph == 2));
    chk("result", result, m_res);
    chk("flags_out", flags_out, m_flg);
    e_a = 8'h00; e_b = 8'h00; e_op = ALU_ADD; e_c = 1'b0;
    if (ph == 1) begin
      e_a  = m_a[7:0];
      e_b  = (m_op < 2) ? m_b[7:0] : 8'h01;
      e_op = (m_op == 3) ? ALU_SUB : ALU_ADD;
    end else if (ph == 2) begin
      e_a  = m_a[15:8];
      e_b  = (m_op == 0) ? m_b[15:8] : (m_op == 1) ? {8{m_b[7]}} : 8'h00;
      e_op = (m_op == 3) ? ALU_SBC : ALU_ADC;
      case (m_op)
        2'd2:    e_c = (m_a[7:0] == 8'hFF);
        2'd3:    e_c = (m_a[7:0] == 8'h00);
        default: e_c = (int'(m_a[7:0]) + int'(m_b[7:0])) > 255;
      endcase
    end
    chk("alu_a", alu_a, e_a);
    chk("alu_b", alu_b, e_b);
    chk("alu_op", alu_op, e_op);
    if (ph == 0) chk("alu_flags_idle", alu_flags, 4'h0);
    else chk("alu_flags_c", alu_flags.c, e_c);
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ph == 0) begin ok = 1; break; end
    end
    chk("wait_idle", ok, 1'b1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] f,
                        input logic [15:0] er, input logic [3:0] ef);
    int n = 0;
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; op16 = op; a16 = a; b16 = b; flags_in = f;
    @(posedge clk); #2;
    start = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); op16 = 2'($urandom);
    flags_in = 4'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin n = k; break; end
    end
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_result"}, result, er);
    chk({nm, "_flags"}, flags_out, ef);
    chk({nm, "_model_result"}, m_res, er);
    chk({nm, "_model_flags"}, m_flg, ef);
  endtask

  int done_at[$];
  int r;

  initial begin
    rst = 1'b1; start = 1'b0; op16 = '0; a16 = '0; b16 = '0; flags_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", flags_out, 4'h0);
    chk("rst_alu_en", alu_en, 1'b0);
    @(posedge clk); #2 rst = 1'b0;

    run_op("add16_h",   2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
    run_op("add16_wrap", 2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
    run_op("addsp_neg", 2'd1, 16'h0005, 16'h12FE, 4'b1111, 16'h0003, 4'b0011);
    run_op("addsp_pos", 2'd1, 16'hFFF8, 16'h0008, 4'b0000, 16'h0000, 4'b0011);
    run_op("dec16_wrap", 2'd3, 16'h0000, 16'h5555, 4'b1010, 16'hFFFF, 4'b1010);
    run_op("inc16",     2'd2, 16'h00FF, 16'hAAAA, 4'b0101, 16'h0100, 4'b0101);

    // start held high with operands churning every cycle
    wait_idle();
    @(posedge clk); #2 start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) done_at.push_back(i);
      @(posedge clk); #2;
      op16 = 2'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); flags_in = 4'($urandom);
    end
    start = 1'b0;
    chk("cont_done_count", done_at.size(), 5);
    if (done_at.size() > 0) chk("cont_first_done", done_at[0], 4);
    for (int i = 1; i < done_at.size(); i++) chk("cont_done_gap", done_at[i] - done_at[i-1], 4);

    // reset during the high pass
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; op16 = 2'd0; a16 = 16'h1234; b16 = 16'h4321; flags_in = 4'b0000;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_high", alu_op, ALU_ADC);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 16'h0000);
    chk("abort_flags", flags_out, 4'h0);
    chk("abort_alu_en", alu_en, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
    run_op("after_abort", 2'd0, 16'h1234, 16'h4321, 4'b0000, 16'h5555, 4'b0000);

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) != 0);
      op16  = 2'($urandom);
      r = $urandom_range(0, 3);
      a16 = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
      r = $urandom_range(0, 3);
      b16 = (r == 0) ? 16'h00FF : (r == 1) ? 16'h0080 : 16'($urandom);
      flags_in = 4'($urandom);
    end
    @(posedge clk); #2 rst = 1'b0; start = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a 16-bit operation; sampled only in IDLE.
REQ-004 SHALL have port op16, input, 2 bits: operation select, with 0=ADD16 (a16+b16), 1=ADDSP (a16+sign-extended b16[7:0]), 2=INC16, 3=DEC16.
REQ-005 SHALL have port a16, input, 16 bits: first operand (HL or SP, or the register pair for INC16/DEC16).
REQ-006 SHALL have port b16, input, 16 bits: second operand; only b16[7:0] is used for ADDSP; ignored for INC16/DEC16.
REQ-007 SHALL have port flags_in, input, flags_t (4 bits, {Z,N,H,C}): CPU flags at start.
REQ-008 SHALL have port busy, output, 1 bit: high in states LOW, HIGH and DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port result, output, 16 bits: completed result, held until the next completion.
REQ-011 SHALL have port flags_out, output, flags_t: completed flags, held until the next completion.
REQ-012 SHALL have port alu_en, output, 1 bit: ALU enable, high only in LOW and HIGH.
REQ-013 SHALL have ports alu_a and alu_b, output, 8 bits each: ALU operands.
REQ-014 SHALL have port alu_op, output, alu_op_t: ALU operation.
REQ-015 SHALL have port alu_flags, output, flags_t: flags fed to the ALU.
REQ-016 SHALL have port alu_res, input, 8 bits: combinational ALU result.
REQ-017 SHALL have port alu_flags_out, input, flags_t: combinational ALU flags.

Function
REQ-018 SHALL implement FSM states IDLE, LOW, HIGH and DONE, with transitions IDLE->LOW on start, LOW->HIGH, HIGH->DONE, DONE->IDLE, all unconditional except the first.
REQ-019 SHALL, on start in IDLE, latch op16, a16, b16 and flags_in; start outside IDLE SHALL be ignored with no queuing.
REQ-020 SHALL, in LOW, drive alu_a=a[7:0] and set alu_flags.C=0; for ADD16 and ADDSP, alu_b=b[7:0] with op ADD; for INC16, alu_b=0x01 with op ADD; for DEC16, alu_b=0x01 with op SUB.
REQ-021 SHALL register alu_res as the low byte and alu_flags_out as the low-pass flags at the end of LOW.
REQ-022 SHALL, in HIGH, drive alu_a=a[15:8] and set alu_flags.C to the low-pass C; for ADD16, alu_b=b[15:8] with op ADC; for ADDSP, alu_b=0xFF if b[7]=1, else 0x00, with op ADC; for INC16, alu_b=0x00 with op ADC; for DEC16, alu_b=0x00 with op SBC.
REQ-023 SHALL, at the end of HIGH, register result={alu_res, low byte} and the final flags.
REQ-024 SHALL produce ADD16 flags as Z=latched Z, N=0, and H and C from the high-pass ALU flags (bit-11 and bit-15 carries).
REQ-025 SHALL produce ADDSP flags as Z=0, N=0, and H and C from the low-pass ALU flags (bit-3 and bit-7 carries).
REQ-026 SHALL produce INC16 and DEC16 flags equal to the latched flags_in, unchanged.
REQ-027 SHALL assert done for exactly the DONE cycle, with result and flags_out valid from that cycle onward; latency from the start-sampling edge to done high is 3 cycles.
REQ-028 SHALL accept a start asserted in the DONE cycle only after returning to IDLE, giving a minimum issue interval of 4 cycles.
REQ-029 SHALL, when alu_en=0, drive alu_a, alu_b and alu_flags to 0 and alu_op to ADD.
REQ-030 SHALL wrap 16-bit arithmetic modulo 2^16 (0xFFFF+1=0x0000 and 0x0000-1=0xFFFF).

Reset
REQ-031 SHALL, while rst is high, immediately force state=IDLE and busy=0, done=0, result=0x0000, flags_out=0, alu_en=0, and clear all latched operands.
REQ-032 SHALL, when rst is asserted mid-operation, abort the operation with no done pulse, leaving result and flags_out at 0.

Verification
REQ-033 SHALL verify ADD16: a16=0x0FFF, b16=0x0001, flags_in=1000 -> result=0x1000, flags_out={Z1,N0,H1,C0}, with done on the 3rd cycle.
REQ-034 SHALL verify ADD16: a16=0xFFFF, b16=0x0001, flags_in=0000 -> result=0x0000, flags_out={0,0,1,1}.
REQ-035 SHALL verify ADDSP: a16=0x0005, b16[7:0]=0xFE -> result=0x0003, flags_out={0,0,1,1}; and a16=0xFFF8, b16[7:0]=0x08 -> result=0x0000, flags_out={0,0,1,1}.
REQ-036 SHALL verify DEC16: a16=0x0000, flags_in=1010 -> result=0xFFFF, flags_out=1010; and INC16: a16=0x00FF -> result=0x0100.
REQ-037 SHALL verify that start held high continuously yields done every 4th cycle and that operand changes while busy do not alter the result.
REQ-038 SHALL verify that rst pulsed during HIGH gives no done, busy=0 and result=0x0000 immediately, and that the next start completes normally.
